// File: rtl/sync_rx_pkt_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_rx_pkt_fifo_pkg
// Shared definitions for the single-clock packet FIFOs (RX and TX side):
// receive FSM state encodings and default data/address widths.
// No ports (package).
// ----------------------------------------------------------------------------
package sync_rx_pkt_fifo_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_ASIZE = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_pkt_fifo_ram.sv
// ----------------------------------------------------------------------------
// sync_pkt_fifo_ram
// Simple dual-port RAM for the packet FIFOs: synchronous write port,
// registered read port with read enable. The array itself has no reset so it
// maps onto block RAM; only the read data register is cleared by RSTn.
// Ports:
//   CLK      clock
//   RSTn     asynchronous active-low reset (read data register only)
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data updates on the next edge, otherwise holds
//   rd_addr  read address
//   rd_data  registered read data
// ----------------------------------------------------------------------------
module sync_pkt_fifo_ram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 9
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    logic [DSIZE-1:0] mem [0:(2**ASIZE)-1];

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_rx_pkt_fifo.sv
// ----------------------------------------------------------------------------
// sync_rx_pkt_fifo
// Receive packet FIFO between the USB packet receiver and the application.
// Bytes are written speculatively at wp; a packet only becomes readable when
// the receiver commits it with pktfin (pkt_wp catches up to wp). CRC error,
// overflow or abort roll wp back to pkt_wp.
// Ports:
//   CLK, RSTn   clock, asynchronous active-low reset
//   rxact       receiver packet active (high for the whole packet)
//   write/iData received byte and its valid
//   pktfin      pulse: commit current packet
//   pkterr      pulse: discard current packet
//   read/oData  pop one committed byte; oData valid one cycle later, then held
//   rdnum       committed bytes available (registered, one cycle behind)
//   full        write side full, uncommitted bytes included
//   empty       no committed bytes
//   pkt_ok      pulse after a commit
//   pkt_drop    pulse after a rollback
// ----------------------------------------------------------------------------
module sync_rx_pkt_fifo
    import sync_rx_pkt_fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             rxact,
    input  logic             write,
    input  logic [DSIZE-1:0] iData,
    input  logic             pktfin,
    input  logic             pkterr,
    input  logic             read,
    output logic [DSIZE-1:0] oData,
    output logic [ASIZE:0]   rdnum,
    output logic             full,
    output logic             empty,
    output logic             pkt_ok,
    output logic             pkt_drop
);

    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    rx_state_t      state, state_nxt;
    logic [ASIZE:0] wp, pkt_wp, rp;
    logic [ASIZE:0] wp_nxt, pkt_wp_nxt;
    logic           rxact_d0, rxact_rise, rxact_fall;
    logic           wr_accept, rd_accept, overflow;
    logic           ok_nxt, drop_nxt;

    // Full compares against the speculative pointer, so uncommitted bytes
    // count; empty compares against the committed pointer, so a reader can
    // never reach bytes that may still be rolled back.
    assign full       = (wp[ASIZE] ^ rp[ASIZE]) & (wp[ASIZE-1:0] == rp[ASIZE-1:0]);
    assign empty      = (pkt_wp == rp);
    assign rxact_rise = rxact & ~rxact_d0;
    assign rxact_fall = rxact_d0 & ~rxact;
    assign wr_accept  = (state == RECV) & write & ~full;
    assign overflow   = (state == RECV) & write & full;
    assign rd_accept  = read & ~empty;

    sync_pkt_fifo_ram #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_ram (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .wr_en  (wr_accept),
        .wr_addr(wp[ASIZE-1:0]),
        .wr_data(iData),
        .rd_en  (rd_accept),
        .rd_addr(rp[ASIZE-1:0]),
        .rd_data(oData)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Same-cycle priority in RECV: overflow, then pkterr, then pktfin, then abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rxact_rise) state_nxt = RECV;
            RECV: begin
                if (overflow || pkterr)
                    state_nxt = DROP;
                else if (pktfin || rxact_fall)
                    state_nxt = IDLE;
            end
            DROP: if (rxact_fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointer updates and status pulses. A write accepted together with
    // pktfin belongs to the committed packet; one accepted with pkterr or
    // an abort is discarded by the rollback.
    always_comb begin
        wp_nxt     = wp;
        pkt_wp_nxt = pkt_wp;
        ok_nxt     = 1'b0;
        drop_nxt   = 1'b0;
        if (state == RECV) begin
            if (overflow || pkterr) begin
                wp_nxt   = pkt_wp;
                drop_nxt = 1'b1;
            end else if (pktfin) begin
                wp_nxt     = wr_accept ? wp + PTR_ONE : wp;
                pkt_wp_nxt = wr_accept ? wp + PTR_ONE : wp;
                ok_nxt     = 1'b1;
            end else if (rxact_fall) begin
                wp_nxt   = pkt_wp;
                drop_nxt = 1'b1;
            end else if (wr_accept) begin
                wp_nxt = wp + PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp       <= '0;
            pkt_wp   <= '0;
            rp       <= '0;
            rxact_d0 <= 1'b0;
            rdnum    <= '0;
            pkt_ok   <= 1'b0;
            pkt_drop <= 1'b0;
        end else begin
            wp       <= wp_nxt;
            pkt_wp   <= pkt_wp_nxt;
            rxact_d0 <= rxact;
            rdnum    <= pkt_wp - rp;
            pkt_ok   <= ok_nxt;
            pkt_drop <= drop_nxt;
            if (rd_accept)
                rp <= rp + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_sync_rx_pkt_fifo.sv
// ----------------------------------------------------------------------------
// tb_sync_rx_pkt_fifo
// Directed self-checking bench for sync_rx_pkt_fifo. Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point, i.e. they show
// the effect of the edge just taken.
// ----------------------------------------------------------------------------
module tb_sync_rx_pkt_fifo;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       rxact = 1'b0;
    logic       write = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       pktfin = 1'b0;
    logic       pkterr = 1'b0;
    logic       read = 1'b0;
    logic [7:0] oData;
    logic [9:0] rdnum;
    logic       full, empty, pkt_ok, pkt_drop;

    int checks = 0;
    int failures = 0;

    sync_rx_pkt_fifo dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .rxact   (rxact),
        .write   (write),
        .iData   (iData),
        .pktfin  (pktfin),
        .pkterr  (pkterr),
        .read    (read),
        .oData   (oData),
        .rdnum   (rdnum),
        .full    (full),
        .empty   (empty),
        .pkt_ok  (pkt_ok),
        .pkt_drop(pkt_drop)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Apply one cycle of inputs, take the edge, land 1 unit after it.
    task automatic drive(input logic rx, input logic wr, input logic [7:0] d,
                         input logic fin, input logic err, input logic rd);
        rxact  = rx;
        write  = wr;
        iData  = d;
        pktfin = fin;
        pkterr = err;
        read   = rd;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (empty !== 1'b1)     begin failures++; $display("[TB] FAIL rst_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0)      begin failures++; $display("[TB] FAIL rst_full got=%0b exp=0", full); end
        checks++; if (rdnum !== 10'd0)    begin failures++; $display("[TB] FAIL rst_rdnum got=%0d exp=0", rdnum); end
        checks++; if (oData !== 8'h00)    begin failures++; $display("[TB] FAIL rst_oData got=%0h exp=0", oData); end
        checks++; if (pkt_ok !== 1'b0)    begin failures++; $display("[TB] FAIL rst_pkt_ok got=%0b exp=0", pkt_ok); end
        checks++; if (pkt_drop !== 1'b0)  begin failures++; $display("[TB] FAIL rst_pkt_drop got=%0b exp=0", pkt_drop); end
        RSTn = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_basic_packet();
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, 8'(i), (i == 63), 0, 0);
            if (i == 62) begin
                checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL t1_uncommitted_empty got=%0b exp=1", empty); end
            end
        end
        checks++; if (pkt_ok !== 1'b1)  begin failures++; $display("[TB] FAIL t1_pkt_ok got=%0b exp=1", pkt_ok); end
        checks++; if (empty !== 1'b0)   begin failures++; $display("[TB] FAIL t1_empty_after_commit got=%0b exp=0", empty); end
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (pkt_ok !== 1'b0)  begin failures++; $display("[TB] FAIL t1_pkt_ok_pulse got=%0b exp=0", pkt_ok); end
        checks++; if (rdnum !== 10'd64) begin failures++; $display("[TB] FAIL t1_rdnum got=%0d exp=64", rdnum); end
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, 8'h00, 0, 0, 1);
            checks++; if (oData !== 8'(i)) begin failures++; $display("[TB] FAIL t1_read%0d got=%0h exp=%0h", i, oData, 8'(i)); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL t1_empty_end got=%0b exp=1", empty); end
        drive(0, 0, 8'h00, 0, 0, 1);
        checks++; if (oData !== 8'h3F) begin failures++; $display("[TB] FAIL t1_hold_on_empty got=%0h exp=3f", oData); end
        checks++; if (rdnum !== 10'd0) begin failures++; $display("[TB] FAIL t1_rdnum_end got=%0d exp=0", rdnum); end
        drive(0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_crc_error();
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 32; i++) drive(1, 1, 8'(8'hA0 + i), 0, 0, 0);
        drive(1, 0, 8'h00, 0, 1, 0);
        checks++; if (pkt_drop !== 1'b1) begin failures++; $display("[TB] FAIL t2_pkt_drop got=%0b exp=1", pkt_drop); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("[TB] FAIL t2_empty got=%0b exp=1", empty); end
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL t2_drop_pulse got=%0b exp=0", pkt_drop); end
        checks++; if (rdnum !== 10'd0)   begin failures++; $display("[TB] FAIL t2_rdnum got=%0d exp=0", rdnum); end
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 8'(8'h10 + i), (i == 7), 0, 0);
        checks++; if (pkt_ok !== 1'b1)   begin failures++; $display("[TB] FAIL t2_pkt_ok got=%0b exp=1", pkt_ok); end
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (rdnum !== 10'd8)   begin failures++; $display("[TB] FAIL t2_rdnum_good got=%0d exp=8", rdnum); end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 8'h00, 0, 0, 1);
            checks++; if (oData !== 8'(8'h10 + i)) begin failures++; $display("[TB] FAIL t2_read%0d got=%0h exp=%0h", i, oData, 8'(8'h10 + i)); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL t2_empty_end got=%0b exp=1", empty); end
    endtask

    task automatic test_overflow();
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 500; i++) drive(1, 1, 8'(i * 7), (i == 499), 0, 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (rdnum !== 10'd500) begin failures++; $display("[TB] FAIL t3_rdnum_500 got=%0d exp=500", rdnum); end
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 8'hEE, 0, 0, 0);
            if (i == 10) begin
                checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL t3_not_full_11 got=%0b exp=0", full); end
            end
        end
        checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL t3_full_12 got=%0b exp=1", full); end
        drive(1, 1, 8'hEE, 0, 0, 0);
        checks++; if (pkt_drop !== 1'b1) begin failures++; $display("[TB] FAIL t3_overflow_drop got=%0b exp=1", pkt_drop); end
        checks++; if (full !== 1'b0)     begin failures++; $display("[TB] FAIL t3_full_after_rollback got=%0b exp=0", full); end
        drive(1, 1, 8'hEE, 1, 0, 0);
        checks++; if (pkt_ok !== 1'b0)   begin failures++; $display("[TB] FAIL t3_pktfin_ignored got=%0b exp=0", pkt_ok); end
        checks++; if (rdnum !== 10'd500) begin failures++; $display("[TB] FAIL t3_rdnum_kept got=%0d exp=500", rdnum); end
        drive(0, 0, 8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (rdnum !== 10'd500) begin failures++; $display("[TB] FAIL t3_rdnum_after got=%0d exp=500", rdnum); end
        for (int i = 0; i < 500; i++) begin
            drive(0, 0, 8'h00, 0, 0, 1);
            checks++; if (oData !== 8'(i * 7)) begin failures++; $display("[TB] FAIL t3_read%0d got=%0h exp=%0h", i, oData, 8'(i * 7)); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL t3_empty_end got=%0b exp=1", empty); end
    endtask

    task automatic test_abort();
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 8'(8'h50 + i), 0, 0, 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (pkt_drop !== 1'b1) begin failures++; $display("[TB] FAIL t4_abort_drop got=%0b exp=1", pkt_drop); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("[TB] FAIL t4_empty got=%0b exp=1", empty); end
        drive(0, 1, 8'h77, 1, 0, 0);
        checks++; if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL t4_drop_pulse got=%0b exp=0", pkt_drop); end
        checks++; if (rdnum !== 10'd0)   begin failures++; $display("[TB] FAIL t4_rdnum got=%0d exp=0", rdnum); end
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (pkt_ok !== 1'b0)   begin failures++; $display("[TB] FAIL t4_idle_ignores_pktfin got=%0b exp=0", pkt_ok); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("[TB] FAIL t4_idle_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] pkt[$];
        logic [7:0] exp_b;
        logic       rd;
        int         committed, rdtotal, k, prev;
        committed = 0;
        rdtotal   = 0;
        k         = 0;
        for (int p = 0; p < 20; p++) begin
            prev = committed - rdtotal;
            drive(1, 0, 8'h00, 0, 0, 0);
            checks++; if (rdnum !== 10'(prev)) begin failures++; $display("[TB] FAIL t5_rdnum_start%0d got=%0d exp=%0d", p, rdnum, prev); end
            for (int i = 0; i < 100; i++) begin
                prev = committed - rdtotal;
                rd   = (prev > 0);
                drive(1, 1, 8'(k * 3 + 1), (i == 99), 0, rd);
                pkt.push_back(8'(k * 3 + 1));
                k++;
                if (rd) begin
                    exp_b = exp_q.pop_front();
                    rdtotal++;
                    checks++; if (oData !== exp_b) begin failures++; $display("[TB] FAIL t5_data p%0d i%0d got=%0h exp=%0h", p, i, oData, exp_b); end
                end
                checks++; if (rdnum !== 10'(prev)) begin failures++; $display("[TB] FAIL t5_rdnum p%0d i%0d got=%0d exp=%0d", p, i, rdnum, prev); end
                if (i == 99) begin
                    foreach (pkt[j]) exp_q.push_back(pkt[j]);
                    pkt.delete();
                    committed += 100;
                end
            end
            drive(0, 0, 8'h00, 0, 0, 0);
        end
        for (int n = 0; n < 200 && (committed - rdtotal) > 0; n++) begin
            drive(0, 0, 8'h00, 0, 0, 1);
            exp_b = exp_q.pop_front();
            rdtotal++;
            checks++; if (oData !== exp_b) begin failures++; $display("[TB] FAIL t5_drain%0d got=%0h exp=%0h", n, oData, exp_b); end
        end
        checks++; if (rdtotal !== 2000) begin failures++; $display("[TB] FAIL t5_total_read got=%0d exp=2000", rdtotal); end
        checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL t5_empty_end got=%0b exp=1", empty); end
    endtask

    task automatic test_reset_mid_packet();
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 8'(8'hC1 + i), (i == 2), 0, 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 0, 0, 1);
        checks++; if (oData !== 8'hC1) begin failures++; $display("[TB] FAIL t6_pre_oData got=%0h exp=c1", oData); end
        drive(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 1, 8'(i + 1), 0, 0, 0);
        write = 1'b1;
        RSTn  = 1'b0;
        #1;
        checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL t6_async_empty got=%0b exp=1", empty); end
        checks++; if (oData !== 8'h00)  begin failures++; $display("[TB] FAIL t6_async_oData got=%0h exp=0", oData); end
        @(posedge CLK);
        #1;
        checks++; if (rdnum !== 10'd0)   begin failures++; $display("[TB] FAIL t6_rdnum got=%0d exp=0", rdnum); end
        checks++; if (full !== 1'b0)     begin failures++; $display("[TB] FAIL t6_full got=%0b exp=0", full); end
        checks++; if (pkt_ok !== 1'b0)   begin failures++; $display("[TB] FAIL t6_pkt_ok got=%0b exp=0", pkt_ok); end
        checks++; if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL t6_pkt_drop got=%0b exp=0", pkt_drop); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("[TB] FAIL t6_empty got=%0b exp=1", empty); end
        RSTn = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 0);
        checks++; if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL t6_post_pkt_drop got=%0b exp=0", pkt_drop); end
        checks++; if (empty !== 1'b1)    begin failures++; $display("[TB] FAIL t6_post_empty got=%0b exp=1", empty); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic_packet();
        test_crc_error();
        test_overflow();
        test_abort();
        test_wrap();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
